// File: rtl/mult_cdb_stage.sv
// mult_cdb_stage: completion stage behind the pipelined 64-bit multiplier.
// Carries each issued multiply's tag and ROB index through a shadow pipeline
// that matches the multiplier's latency. Products are buffered in a small
// completion FIFO until the CDB grants a broadcast slot. A credit check on
// issue guarantees that a product is never dropped.
// Optional build macro: MULT_CDB_BYPASS_EN. When it is defined, an arriving
// product is broadcast in its arrive cycle if the FIFO is empty.
module mult_cdb_stage #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned ROB_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_flush,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic [ROB_W-1:0] issue_rob,
    input  logic [63:0]      mult_result,
    output logic             cdb_req,
    input  logic             cdb_gnt,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [ROB_W-1:0] cdb_rob,
    output logic [63:0]      cdb_data
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // Shadow pipeline: one slot per multiplier stage.
    logic [LATENCY-1:0] sh_valid;
    logic [TAG_W-1:0]   sh_tag [LATENCY];
    logic [ROB_W-1:0]   sh_rob [LATENCY];

    // Completion FIFO storage and bookkeeping.
    logic [TAG_W-1:0]   mem_tag  [DEPTH];
    logic [ROB_W-1:0]   mem_rob  [DEPTH];
    logic [63:0]        mem_data [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   inflight;

    logic accept;
    logic arrive;
    logic fifo_empty;
    logic bypass_take;
    logic push;
    logic pop;

    // Count the ops currently travelling through the multiplier.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + CNT_W'(sh_valid[i]);
        end
    end

    assign fifo_empty  = (count == '0);
    assign arrive      = sh_valid[LATENCY-1];
    // A same-cycle pop is deliberately not credited here, which keeps the
    // ready path short. In exchange, a push can never meet a full FIFO.
    assign issue_ready = (inflight + count) < CNT_W'(DEPTH);
    assign accept      = issue_valid & issue_ready & ~pipe_flush;

`ifdef MULT_CDB_BYPASS_EN
    // An empty FIFO lets the arriving product go straight to the CDB.
    always_comb begin
        cdb_req     = (~fifo_empty | arrive) & ~pipe_flush;
        bypass_take = fifo_empty & arrive & cdb_gnt & ~pipe_flush;
        if (fifo_empty && arrive) begin
            cdb_tag  = sh_tag[LATENCY-1];
            cdb_rob  = sh_rob[LATENCY-1];
            cdb_data = mult_result;
        end else begin
            cdb_tag  = mem_tag[rd_ptr];
            cdb_rob  = mem_rob[rd_ptr];
            cdb_data = mem_data[rd_ptr];
        end
    end
`else
    // Every broadcast comes from the FIFO head.
    always_comb begin
        cdb_req     = ~fifo_empty & ~pipe_flush;
        bypass_take = 1'b0;
        cdb_tag     = mem_tag[rd_ptr];
        cdb_rob     = mem_rob[rd_ptr];
        cdb_data    = mem_data[rd_ptr];
    end
`endif

    assign push = arrive & ~pipe_flush & ~bypass_take;
    assign pop  = cdb_req & cdb_gnt & ~fifo_empty;

    // Shift the shadow pipeline every cycle. A flush kills all valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                sh_tag[i] <= '0;
                sh_rob[i] <= '0;
            end
        end else begin
            sh_valid[0] <= accept;
            sh_tag[0]   <= issue_tag;
            sh_rob[0]   <= issue_rob;
            for (int i = 1; i < LATENCY; i++) begin
                sh_valid[i] <= sh_valid[i-1];
                sh_tag[i]   <= sh_tag[i-1];
                sh_rob[i]   <= sh_rob[i-1];
            end
            if (pipe_flush) begin
                sh_valid <= '0;
            end
        end
    end

    // Completion FIFO. The storage is reset so the head reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_tag[i]  <= '0;
                mem_rob[i]  <= '0;
                mem_data[i] <= '0;
            end
        end else if (pipe_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_tag[wr_ptr]  <= sh_tag[LATENCY-1];
                mem_rob[wr_ptr]  <= sh_rob[LATENCY-1];
                mem_data[wr_ptr] <= mult_result;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/mult_cdb_stage.md
# mult_cdb_stage

Completion stage directly downstream of the 2-stage pipelined 64-bit multiplier in the R10K integer execution cluster. It carries each issued multiply's destination physical-register tag and ROB index through a shadow pipeline aligned with the multiplier's datapath latency. It captures the 64-bit product when it emerges and buffers results in a small completion FIFO until the CDB arbiter grants a broadcast slot. It also throttles issue with a credit check, so a product can never be lost when the CDB is busy.

## Interface
- LATENCY, 2: multiplier latency in cycles; must match the multiplier pipeline depth.
- DEPTH, 4: completion FIFO entries; power of two, ≥ 2.
- TAG_W, 6: physical register tag width.
- ROB_W, 5: ROB index width.

- clk  in  1  sole clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- pipe_flush  in  1  synchronous flush; also drives the multiplier's flush.
- issue_valid  in  1  a multiply is presented to the multiplier this cycle.
- issue_ready  out  1  the stage can accept a multiply this cycle.
- issue_tag  in  TAG_W  destination tag.
- issue_rob  in  ROB_W  ROB index.
- mult_result  in  64  multiplier output.
- cdb_req  out  1  broadcast request.
- cdb_gnt  in  1  grant, same cycle as the request it answers.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_rob  out  ROB_W  broadcast ROB index.
- cdb_data  out  64  broadcast product.

## Operation
- Accept = issue_valid & issue_ready & ~pipe_flush. On accept, {1, issue_tag, issue_rob} enters shadow stage 0. Each stage shifts by one per cycle, unconditionally.
- Stage LATENCY-1 valid ("arrive") means mult_result holds that op's product this cycle. At the clock edge, {tag, rob, mult_result} is pushed into the FIFO.
- inflight = number of valid shadow stages. count = FIFO occupancy.
- issue_ready = (inflight + count) < DEPTH. This check is conservative: a same-cycle pop is not credited. The check guarantees that a push never finds the FIFO full.
- cdb_req = (count != 0) & ~pipe_flush. cdb_tag, cdb_rob and cdb_data come from the FIFO head.
- A pop occurs on cdb_req & cdb_gnt. cdb_gnt without cdb_req is ignored.
- A push and a pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- pipe_flush clears every shadow valid bit, the FIFO pointers and count. It takes priority over accept, push and pop. The broadcast in a flush cycle is suppressed.
- Arithmetic: inflight + count is compared at width clog2(DEPTH)+1. There is no overflow, because the sum never exceeds DEPTH.
- Reset values: issue_ready=1, cdb_req=0, cdb_tag=0, cdb_rob=0, cdb_data=0. All shadow valid bits, pointers and count are 0.
- Reset asserted mid-operation discards all in-flight ops and buffered entries immediately (asynchronous reset).

## Timing
- An op accepted in cycle T arrives in cycle T+LATENCY.
- The earliest cdb_req for that op is cycle T+LATENCY+1 (registered FIFO path).
- The broadcast holds cdb_tag, cdb_rob and cdb_data stable while cdb_req=1 and cdb_gnt=0.
- Throughput is one op per cycle when cdb_gnt is held high.
- issue_ready falls in the cycle after the accept that brings inflight+count to DEPTH.

## Configuration
- MULT_CDB_BYPASS_EN defined:
  - When count==0 and arrive=1, cdb_req asserts in the arrive cycle itself, with the shadow tag/rob and mult_result on the CDB outputs.
  - If cdb_gnt=1, the entry is not pushed.
  - If cdb_gnt=0, it is pushed as normal.
  - Minimum completion latency becomes LATENCY.
- MULT_CDB_BYPASS_EN undefined: all results pass through the FIFO, and minimum latency is LATENCY+1.

## Test plan
- Reset, then accept tag=5, rob=3 in cycle 0 with mult_result=0x2A at cycle 2, cdb_gnt=1:
  - Without the macro: cdb_req=1 in cycle 3 carrying tag 5, rob 3, data 0x2A.
  - With the macro: the same broadcast occurs in cycle 2.
- cdb_gnt=0, issue_valid held high:
  - Exactly 4 ops are accepted and issue_ready=0 from cycle 4.
  - Raising cdb_gnt drains the ops in issue order, 0x10..0x13.
  - issue_ready returns 1 in the cycle after the first pop.
- pipe_flush with 2 in flight and 2 buffered:
  - cdb_req=0 in the flush cycle and after it.
  - issue_ready=1 in the next cycle.
  - No stale broadcast ever appears.
- Accept back-to-back ops every cycle for 20 cycles with cdb_gnt=1:
  - 20 broadcasts occur in consecutive cycles, in order.
  - There are no gaps after the first broadcast.
- Assert rst mid-burst with 3 buffered entries:
  - Outputs go to their reset values without waiting for a clock edge.
  - After release, the first new op's broadcast carries its own tag.
- Same-cycle push and pop with count=2:
  - count stays 2.
  - The head advances to the next entry with correct data.
